// File: rtl/up_or_down_counter_if.sv
// ----------------------------------------------------------------------------
// up_or_down_counter_if
// Signal bundle between the up/down counter and whoever drives it.
//   UpOrDown : direction select, 1 = increment, 0 = decrement
//   count    : current counter value (WIDTH bits)
//   term_cnt : next step wraps (combinational)
//   wrapped  : one-cycle pulse in the cycle after a wrap
// master drives UpOrDown and observes the rest; slave is the counter itself.
// ----------------------------------------------------------------------------
interface up_or_down_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             UpOrDown;
   logic [WIDTH-1:0] count;
   logic             term_cnt;
   logic             wrapped;

   modport master (
      output UpOrDown,
      input  count,
      input  term_cnt,
      input  wrapped
   );

   modport slave (
      input  UpOrDown,
      output count,
      output term_cnt,
      output wrapped
   );
endinterface

// File: rtl/up_or_down_counter.sv
// ----------------------------------------------------------------------------
// up_or_down_counter
// Free-running binary up/down counter, modulo 2^WIDTH, stepping every clock.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset, loads RESET_VALUE, clears wrapped
//   bus    : slave side of up_or_down_counter_if
//            (UpOrDown in; count, term_cnt, wrapped out)
// Parameters:
//   WIDTH       : count width, 1..32
//   RESET_VALUE : value held in count while reset is low
// ----------------------------------------------------------------------------
module up_or_down_counter #(
   parameter int unsigned      WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   up_or_down_counter_if.slave   bus
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrapped_q, wrapped_d;
   logic             at_max, at_min;

   assign at_max = &count_q;
   assign at_min = ~|count_q;

   // An unknown direction falls into the default arm and holds the count,
   // so an X on UpOrDown never spreads into the register.
   always_comb begin
      count_d   = count_q;
      wrapped_d = 1'b0;
      case (bus.UpOrDown)
         1'b1: begin
            count_d   = count_q + ONE;
            wrapped_d = at_max;
         end
         1'b0: begin
            count_d   = count_q - ONE;
            wrapped_d = at_min;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q   <= RESET_VALUE;
         wrapped_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.wrapped  = wrapped_q;
   // Looks ahead at the step the next edge will take; masked during reset.
   assign bus.term_cnt = reset & ((bus.UpOrDown & at_max) | (~bus.UpOrDown & at_min));

endmodule

// File: tb/tb_up_or_down_counter.sv
// ----------------------------------------------------------------------------
// tb_up_or_down_counter
// Three counters share clock, reset and direction: 4-bit (reset 0), 1-bit
// (reset 1) and 8-bit (reset 250). An arithmetic model tracks each one and a
// compare process checks them on every falling edge; directed steps also
// check hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_up_or_down_counter;

   logic clk = 1'b0;
   logic rst_n;
   logic dir;
   logic chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   up_or_down_counter_if #(.WIDTH(4)) if_a ();
   up_or_down_counter_if #(.WIDTH(1)) if_b ();
   up_or_down_counter_if #(.WIDTH(8)) if_c ();

   assign if_a.UpOrDown = dir;
   assign if_b.UpOrDown = dir;
   assign if_c.UpOrDown = dir;

   up_or_down_counter #(.WIDTH(4), .RESET_VALUE(4'd0))   dut_a (.clk(clk), .reset(rst_n), .bus(if_a));
   up_or_down_counter #(.WIDTH(1), .RESET_VALUE(1'b1))   dut_b (.clk(clk), .reset(rst_n), .bus(if_b));
   up_or_down_counter #(.WIDTH(8), .RESET_VALUE(8'd250)) dut_c (.clk(clk), .reset(rst_n), .bus(if_c));

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- model: plain integer arithmetic -----------------
   int     mw_bits [3] = '{4, 1, 8};
   longint m_rv    [3] = '{0, 1, 250};
   longint m_cnt   [3];
   bit     m_wrp   [3];
   longint nxt_m;

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            m_cnt[i] = m_rv[i];
            m_wrp[i] = 1'b0;
         end else begin
            nxt_m    = m_cnt[i] + (dir ? 1 : -1);
            m_wrp[i] = (nxt_m < 0) || (nxt_m >= (64'd1 << mw_bits[i]));
            m_cnt[i] = (nxt_m + (64'd1 << mw_bits[i])) % (64'd1 << mw_bits[i]);
         end
      end
   end

   function automatic bit m_term(input int i);
      longint n;
      n = m_cnt[i] + (dir ? 1 : -1);
      return rst_n && ((n < 0) || (n >= (64'd1 << mw_bits[i])));
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mdl_cnt_w4",  if_a.count,    m_cnt[0]);
         chk("mdl_wrp_w4",  if_a.wrapped,  m_wrp[0]);
         chk("mdl_term_w4", if_a.term_cnt, m_term(0));
         chk("mdl_cnt_w1",  if_b.count,    m_cnt[1]);
         chk("mdl_wrp_w1",  if_b.wrapped,  m_wrp[1]);
         chk("mdl_term_w1", if_b.term_cnt, m_term(1));
         chk("mdl_cnt_w8",  if_c.count,    m_cnt[2]);
         chk("mdl_wrp_w8",  if_c.wrapped,  m_wrp[2]);
         chk("mdl_term_w8", if_c.term_cnt, m_term(2));
      end
   end

   // ---------------- directed stimulus with literal expectations ------
   task automatic step4(input logic d, input int e, input int ew);
      dir = d;
      @(posedge clk);
      #1;
      chk("lit_cnt_w4", if_a.count, e);
      chk("lit_wrp_w4", if_a.wrapped, ew);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int up_exp [18] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0,1,2};
   int b_exp  [4]  = '{0,1,0,1};
   int bw_exp [4]  = '{1,0,1,0};

   initial begin
      rst_n = 1'b0;
      dir   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_cnt_w4",  if_a.count, 0);
      chk("rst_wrp_w4",  if_a.wrapped, 0);
      chk("rst_term_w4", if_a.term_cnt, 0);
      chk("rst_cnt_w1",  if_b.count, 1);
      chk("rst_cnt_w8",  if_c.count, 250);

      // up count across the wrap
      rst_n = 1'b1;
      for (int k = 0; k < 18; k++) begin
         step4(1'b1, up_exp[k], (k == 15) ? 1 : 0);
         if (k == 14) chk("lit_term_max_w4", if_a.term_cnt, 1);
         if (k == 13) chk("lit_term_14_w4", if_a.term_cnt, 0);
         if (k < 4) begin
            chk("lit_cnt_w1", if_b.count, b_exp[k]);
            chk("lit_wrp_w1", if_b.wrapped, bw_exp[k]);
         end
         if (k == 4) chk("lit_cnt255_w8", if_c.count, 255);
         if (k == 5) begin
            chk("lit_cnt0_w8", if_c.count, 0);
            chk("lit_wrp_w8",  if_c.wrapped, 1);
         end
      end

      // climb to 7, then reset asynchronously mid-cycle
      for (int k = 3; k <= 7; k++) step4(1'b1, k, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_cnt_w4",  if_a.count, 0);
      chk("async_term_w4", if_a.term_cnt, 0);
      chk("async_cnt_w8",  if_c.count, 250);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // down count from reset: first edge wraps
      for (int k = 0; k < 16; k++) step4(1'b0, 15 - k, (k == 0) ? 1 : 0);
      chk("lit_term_min_w4", if_a.term_cnt, 1);

      // direction change: up to 5, down twice, up twice
      do_reset();
      for (int k = 1; k <= 5; k++) step4(1'b1, k, 0);
      step4(1'b0, 4, 0);
      step4(1'b0, 3, 0);
      step4(1'b1, 4, 0);
      step4(1'b1, 5, 0);

      // alternate every cycle from 0, then step down through 0
      do_reset();
      step4(1'b1, 1, 0);
      step4(1'b0, 0, 0);
      step4(1'b1, 1, 0);
      step4(1'b0, 0, 0);
      step4(1'b0, 15, 1);
      step4(1'b0, 14, 0);

      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
